expand_subta: RTL

- Encoder-side input path of the G.726 ADPCM datapath. It is the mirror of the decoder reconstruction adder: that adder forms SR = DQ + SE, and this block forms D = SL - SE.
- Accepts one 8-bit log-PCM sample S (A-law or u-law) together with the signal estimate SE.
- Expands S to the 14-bit linear value SL (G.726 EXPAND), then forms the 16-bit difference D = SL - SE (G.726 SUBTA).
- Handshaked, one sample in flight. Feeds the adaptive quantizer.

---
 rtl/expand_subta_pkg.sv | 29 ++
 rtl/expand_subta_if.sv | 27 ++
 rtl/expand_subta_pcm_expand.sv | 39 +++
 rtl/expand_subta.sv | 119 +++++++++++
 4 files changed

// File: rtl/expand_subta_pkg.sv
// rtl/expand_subta_pkg.sv - shared types and constants for the G.726 EXPAND/SUBTA path
package expand_subta_pkg;

    localparam int S_W  = 8;
    localparam int SE_W = 15;
    localparam int SL_W = 14;
    localparam int D_W  = 16;

    localparam logic LAW_ULAW = 1'b0;
    localparam logic LAW_ALAW = 1'b1;

    // Segment bias used by both laws during expansion.
    localparam int EXP_BIAS = 33;

    // A-law even-bit inversion mask.
    localparam logic [S_W-1:0] ALAW_XOR = 8'h55;

    // Offsets that sign-extend SL (14 -> 16) and SE (15 -> 16).
    localparam logic [D_W-1:0] SL_EXT_ADD = 16'd49152;
    localparam logic [D_W-1:0] SE_EXT_ADD = 16'd32768;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        SUB  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/expand_subta_if.sv
// rtl/expand_subta_if.sv - sample-in / difference-out handshake bundle
interface expand_subta_if;
    import expand_subta_pkg::*;

    logic            LAW;
    logic [S_W-1:0]  S;
    logic [SE_W-1:0] SE;
    logic            S_VALID;
    logic            S_READY;
    logic [SL_W-1:0] SL;
    logic [D_W-1:0]  D;
    logic            D_VALID;
    logic            D_READY;

    // Producer of samples and consumer of differences.
    modport master (
        output LAW, S, SE, S_VALID, D_READY,
        input  S_READY, SL, D, D_VALID
    );

    // The expand/subtract block itself.
    modport slave (
        input  LAW, S, SE, S_VALID, D_READY,
        output S_READY, SL, D, D_VALID
    );

endinterface

// File: rtl/expand_subta_pcm_expand.sv
// rtl/expand_subta_pcm_expand.sv - combinational A-law/u-law to 14-bit linear expander
module pcm_expand
    import expand_subta_pkg::*;
(
    input  logic            law,
    input  logic [S_W-1:0]  s,
    output logic [SL_W-1:0] sl
);

    localparam logic [SL_W-1:0] BIAS = SL_W'(EXP_BIAS);

    logic [S_W-1:0]  code;
    logic [2:0]      expo;
    logic [3:0]      mant;
    logic [SL_W-1:0] base;
    logic [SL_W-1:0] mag;
    logic            positive;

    // Undo the line coding, split sign/segment/step, rebuild magnitude and apply sign.
    always_comb begin
        code     = (law == LAW_ALAW) ? (s ^ ALAW_XOR) : ~s;
        expo     = code[6:4];
        mant     = code[3:0];
        base     = {9'd0, mant, 1'b0} + BIAS;
        mag      = '0;
        positive = 1'b0;
        if (law == LAW_ALAW) begin
            positive = code[7];
            // Segment 0 of A-law is linear with no bias.
            mag = (expo == 3'd0) ? {9'd0, mant, 1'b1} : (base << (expo - 3'd1));
        end else begin
            positive = ~code[7];
            mag = (base << expo) - BIAS;
        end
        // Negative zero collapses to zero through the modular negate.
        sl = positive ? mag : (SL_W'(0) - mag);
    end

endmodule

// File: rtl/expand_subta.sv
// rtl/expand_subta.sv - G.726 encoder input path: expand log-PCM then subtract signal estimate
module expand_subta
    import expand_subta_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scan_in0,
    input  logic scan_in1,
    input  logic scan_in2,
    input  logic scan_in3,
    input  logic scan_in4,
    input  logic scan_enable,
    input  logic test_mode,
    output logic scan_out0,
    output logic scan_out1,
    output logic scan_out2,
    output logic scan_out3,
    output logic scan_out4,
    expand_subta_if.slave bus
);

    state_t state, state_next;

    logic [S_W-1:0]  s_q;
    logic [SE_W-1:0] se_q;
    logic            law_q;
    logic [SL_W-1:0] sl_q;
    logic [D_W-1:0]  d_q;

    logic            s_ready;
    logic            d_valid;
    logic            accept;
    logic            exp_en;
    logic            sub_en;

    logic [SL_W-1:0] sl_exp;
    logic [D_W-1:0]  sli;
    logic [D_W-1:0]  sei;
    logic [D_W-1:0]  d_next;

    pcm_expand u_expand (
        .law (law_q),
        .s   (s_q),
        .sl  (sl_exp)
    );

    // Sign-extend both operands to 16 bits and subtract; wrap-around is intended.
    always_comb begin
        sli    = sl_q[SL_W-1] ? ({2'b00, sl_q} + SL_EXT_ADD) : {2'b00, sl_q};
        sei    = se_q[SE_W-1] ? ({1'b0, se_q} + SE_EXT_ADD) : {1'b0, se_q};
        d_next = sli - sei;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one sample in flight, HOLD waits for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.S_VALID) state_next = EXP;
            EXP:     state_next = SUB;
            SUB:     state_next = HOLD;
            HOLD:    if (bus.D_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and datapath enables decoded from the current state.
    always_comb begin
        s_ready = (state == IDLE);
        d_valid = (state == HOLD);
        exp_en  = (state == EXP);
        sub_en  = (state == SUB);
        accept  = s_ready & bus.S_VALID;
    end

    // Datapath registers: input latch on accept, SL in EXP, D in SUB.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q   <= '0;
            se_q  <= '0;
            law_q <= LAW_ULAW;
            sl_q  <= '0;
            d_q   <= '0;
        end else begin
            if (accept) begin
                s_q   <= bus.S;
                se_q  <= bus.SE;
                law_q <= bus.LAW;
            end
            if (exp_en) begin
                sl_q <= sl_exp;
            end
            if (sub_en) begin
                d_q <= d_next;
            end
        end
    end

    assign bus.S_READY = s_ready;
    assign bus.D_VALID = d_valid;
    assign bus.SL      = sl_q;
    assign bus.D       = d_q;

    // Stubs restitched by scan insertion; held low in functional mode.
    assign scan_out0 = test_mode & scan_enable & scan_in0;
    assign scan_out1 = test_mode & scan_enable & scan_in1;
    assign scan_out2 = test_mode & scan_enable & scan_in2;
    assign scan_out3 = test_mode & scan_enable & scan_in3;
    assign scan_out4 = test_mode & scan_enable & scan_in4;

endmodule
